// File: rtl/fir_output_decimator_if.sv
// Output stream bundle of the FIR decimator.
//   m_data  : signed sample at the FIFO head (master -> slave)
//   m_valid : FIFO holds at least one sample (master -> slave)
//   m_ready : downstream accepts m_data this cycle (slave -> master)
interface fir_output_decimator_if #(
  parameter int W = 16
);
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fir_output_decimator.sv
// Consumer end of the FIR output stream: keeps one sample in DECIM, requantizes
// it to OUT_WIDTH bits (round-half-up, saturating) and buffers the result in a
// small FIFO drained over a valid/ready handshake. Never stalls upstream.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   y_in, in_en: FIR output sample and its enable
//   m_if       : output stream (m_data / m_valid / m_ready)
//   sat_pulse  : stage-2 register holds a saturated valid sample
//   ovf, ovf_clr: sticky FIFO-overflow flag and its clear
//   fill       : FIFO occupancy, 0..FIFO_DEPTH
module fir_output_decimator #(
  parameter int IN_WIDTH   = 40,
  parameter int OUT_WIDTH  = 16,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_WIDTH-1:0]           y_in,
  input  logic                          in_en,
  fir_output_decimator_if.master        m_if,
  output logic                          sat_pulse,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);
  localparam int SH   = IN_WIDTH - OUT_WIDTH;
  localparam int QW   = OUT_WIDTH + 1;
  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int FW   = AW + 1;
  localparam logic [IN_WIDTH:0] HALF = {{IN_WIDTH{1'b0}}, 1'b1} << (SH - 1);

  logic [PH_W-1:0]      phase_q, phase_d;
  logic                 keep;
  logic [IN_WIDTH-1:0]  s1_q;
  logic                 s1_vld_q;
  logic [IN_WIDTH:0]    r;
  logic [QW-1:0]        q_top;
  logic                 sat_hi, sat_lo;
  logic [OUT_WIDTH-1:0] s2_d, s2_q;
  logic                 s2_vld_q, s2_sat_q;
  logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]        fill_q, fill_d;
  logic [OUT_WIDTH-1:0] last_q;
  logic                 ovf_q;
  logic                 full, pop, push, drop;

  assign keep = in_en && (phase_q == '0);

  always_comb begin
    phase_d = phase_q;
    if (in_en) phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + 1'b1;
  end

  // Sign-extend to IN_WIDTH+1 so adding the half-LSB cannot wrap; the upper
  // OUT_WIDTH+1 bits of the sum are the rounded quotient. Saturation is
  // exactly the case where its top two bits disagree.
  always_comb begin
    r      = {s1_q[IN_WIDTH-1], s1_q} + HALF;
    q_top  = QW'(r >> SH);
    sat_hi = ~q_top[QW-1] &  q_top[QW-2];
    sat_lo =  q_top[QW-1] & ~q_top[QW-2];
    if (sat_hi)      s2_d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (sat_lo) s2_d = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else             s2_d = q_top[OUT_WIDTH-1:0];
  end

  assign full = (fill_q == FW'(FIFO_DEPTH));
  assign pop  = (fill_q != '0) && m_if.m_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = s2_vld_q && (!full || pop);
  assign drop = s2_vld_q && full && !pop;

  always_comb begin
    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= '0;
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      s2_q     <= '0;
      s2_vld_q <= 1'b0;
      s2_sat_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      s1_vld_q <= keep;
      if (keep) s1_q <= y_in;
      s2_vld_q <= s1_vld_q;
      s2_sat_q <= s1_vld_q && (sat_hi || sat_lo);
      if (s1_vld_q) s2_q <= s2_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
      fill_q <= fill_d;
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // Storage needs no reset: an entry is only read while fill covers it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s2_q;
  end

  // When empty, m_data keeps showing the last sample handed downstream.
  assign m_if.m_valid = (fill_q != '0);
  assign m_if.m_data  = (fill_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign sat_pulse    = s2_sat_q;
  assign ovf          = ovf_q;
  assign fill         = fill_q;
endmodule
